// File: rtl/zbt_ssram_responder_32.sv
// Flow-through ZBT SSRAM responder: decodes the SRAM control pins, runs a one-stage
// data-phase pipeline with a 2-bit burst counter, and returns reads on a split data bus.
module zbt_ssram_responder_32 #(
    parameter int AW       = 22,
    parameter bit BURST_IL = 1'b0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-3:0] SADDR,
    input  logic [31:0]   SDATAIN,
    output logic [31:0]   SDATAOUT,
    output logic          SDATAOE,
    input  logic [3:0]    SnWBYTE,
    input  logic          SnOE,
    input  logic          SnCE,
    input  logic          SADVnLD,
    input  logic          SnWR,
    input  logic          SnCKE,
    output logic          ERRFLAG
);
    localparam int WA = AW - 2;

    logic [31:0]   mem [0:(1<<WA)-1];

    logic          dp_valid;
    logic          dp_write;
    logic [3:0]    dp_be;
    logic [WA-1:0] dp_addr;
    logic [WA-1:0] base;
    logic [1:0]    cnt;
    logic [31:0]   rd_data;
    logic          err;

    logic          en;
    logic          is_load;
    logic          is_desel;
    logic          is_adv;
    logic [1:0]    cnt_nxt;
    logic [1:0]    adv_low;
    logic [WA-1:0] cmd_addr;
    logic          commit;
    logic [31:0]   mem_word;
    logic [31:0]   rd_next;

    // Address-phase decode; an ADVANCE without a live previous op is the error case.
    always_comb begin
        en       = ~SnCKE;
        is_load  = ~SADVnLD & ~SnCE;
        is_desel = ~SADVnLD & SnCE;
        is_adv   = SADVnLD & dp_valid;
        cnt_nxt  = cnt + 2'd1;
        adv_low  = BURST_IL ? (base[1:0] ^ cnt_nxt) : (base[1:0] + cnt_nxt);
        cmd_addr = is_load ? SADDR : {base[WA-1:2], adv_low};
        commit   = en & dp_valid & dp_write;
        mem_word = mem[cmd_addr];
        rd_next  = mem_word;
        // A read hitting the word whose write commits on this same edge sees the new lanes.
        for (int i = 0; i < 4; i++) begin
            if (commit && (dp_addr == cmd_addr) && dp_be[i]) begin
                rd_next[8*i +: 8] = SDATAIN[8*i +: 8];
            end
        end
    end

    // Array is not reset; a reset edge drops the pending write.
    always_ff @(posedge HCLK) begin
        if (HRESETn && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be[i]) begin
                    mem[dp_addr][8*i +: 8] <= SDATAIN[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_be    <= 4'h0;
            dp_addr  <= '0;
            base     <= '0;
            cnt      <= 2'd0;
            rd_data  <= 32'h0;
            err      <= 1'b0;
        end else if (en) begin
            if (is_load) begin
                base     <= SADDR;
                cnt      <= 2'd0;
                dp_valid <= 1'b1;
                dp_write <= ~SnWR;
                dp_be    <= ~SnWBYTE;
                dp_addr  <= SADDR;
                if (SnWR) begin
                    rd_data <= rd_next;
                end
            end else if (is_desel) begin
                dp_valid <= 1'b0;
            end else if (is_adv) begin
                cnt     <= cnt_nxt;
                dp_addr <= cmd_addr;
                dp_be   <= ~SnWBYTE;
                if (!dp_write) begin
                    rd_data <= rd_next;
                end
            end else begin
                dp_valid <= 1'b0;
                err      <= 1'b1;
            end
        end
    end

    assign SDATAOE  = dp_valid & ~dp_write & ~SnOE;
    assign SDATAOUT = rd_data;
    assign ERRFLAG  = err;

endmodule

// File: tb/tb_zbt_ssram_responder_32.sv
// Directed bench for zbt_ssram_responder_32: a linear-burst and an interleaved-burst
// instance share every input; each test task checks hand-computed values inline.
module tb_zbt_ssram_responder_32;
    localparam int AW = 12;

    logic          HCLK;
    logic          HRESETn;
    logic [AW-3:0] SADDR;
    logic [31:0]   SDATAIN;
    logic [3:0]    SnWBYTE;
    logic          SnOE;
    logic          SnCE;
    logic          SADVnLD;
    logic          SnWR;
    logic          SnCKE;
    logic [31:0]   out0, out1;
    logic          oe0, oe1;
    logic          err0, err1;

    int total = 0;
    int bad = 0;

    zbt_ssram_responder_32 #(.AW(AW), .BURST_IL(1'b0)) dut_lin (
        .HCLK(HCLK), .HRESETn(HRESETn), .SADDR(SADDR), .SDATAIN(SDATAIN),
        .SDATAOUT(out0), .SDATAOE(oe0), .SnWBYTE(SnWBYTE), .SnOE(SnOE), .SnCE(SnCE),
        .SADVnLD(SADVnLD), .SnWR(SnWR), .SnCKE(SnCKE), .ERRFLAG(err0)
    );

    zbt_ssram_responder_32 #(.AW(AW), .BURST_IL(1'b1)) dut_il (
        .HCLK(HCLK), .HRESETn(HRESETn), .SADDR(SADDR), .SDATAIN(SDATAIN),
        .SDATAOUT(out1), .SDATAOE(oe1), .SnWBYTE(SnWBYTE), .SnOE(SnOE), .SnCE(SnCE),
        .SADVnLD(SADVnLD), .SnWR(SnWR), .SnCKE(SnCKE), .ERRFLAG(err1)
    );

    // clock / reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // driver tasks: inputs change 1 time unit after the rising edge, outputs are sampled there too
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv_load(input logic [AW-3:0] a, input logic wr, input logic [3:0] be_n);
        SnCKE   = 1'b0;
        SADVnLD = 1'b0;
        SnCE    = 1'b0;
        SADDR   = a;
        SnWR    = ~wr;
        SnWBYTE = be_n;
        cyc();
    endtask

    task automatic drv_adv(input logic [3:0] be_n);
        SnCKE   = 1'b0;
        SADVnLD = 1'b1;
        SnCE    = 1'b1;
        SnWBYTE = be_n;
        cyc();
    endtask

    task automatic drv_desel();
        SnCKE   = 1'b0;
        SADVnLD = 1'b0;
        SnCE    = 1'b1;
        SnWBYTE = 4'hF;
        cyc();
    endtask

    task automatic write_word(input logic [AW-3:0] a, input logic [31:0] d, input logic [3:0] be_n);
        drv_load(a, 1'b1, be_n);
        SDATAIN = d;
        drv_desel();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) cyc();
        total++; if (out0 !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", out0, 32'h0); end
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", oe0); end
        total++; if (err0 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", err0, err1); end
        HRESETn = 1'b1;
        drv_desel();
    endtask

    task automatic test_word_rw();
        drv_load(10'h010, 1'b1, 4'h0);
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL word_wr_oe got=%b exp=0", oe0); end
        SDATAIN = 32'hDEADBEEF;
        drv_load(10'h010, 1'b0, 4'hF);
        total++; if (out0 !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd got=%h exp=deadbeef", out0); end
        total++; if (oe0 !== 1'b1) begin bad++; $display("FAIL word_rd_oe got=%b exp=1", oe0); end
        drv_desel();
        total++; if (oe0 !== 1'b0 || out0 !== 32'hDEADBEEF) begin bad++; $display("FAIL word_hold got=%b/%h exp=0/deadbeef", oe0, out0); end
        // array read (no bypass) with SnOE released, then asserted combinationally
        SnOE = 1'b1;
        drv_load(10'h010, 1'b0, 4'hF);
        total++; if (oe0 !== 1'b0 || out0 !== 32'hDEADBEEF) begin bad++; $display("FAIL word_snoe_hi got=%b/%h exp=0/deadbeef", oe0, out0); end
        SnOE = 1'b0;
        #1;
        total++; if (oe0 !== 1'b1) begin bad++; $display("FAIL word_snoe_lo got=%b exp=1", oe0); end
        drv_desel();
    endtask

    task automatic test_byte_lanes();
        write_word(10'h020, 32'h11223344, 4'b0000);
        write_word(10'h020, 32'hAABBCCDD, 4'b1101);
        drv_load(10'h020, 1'b0, 4'hF);
        total++; if (out0 !== 32'h1122CC44) begin bad++; $display("FAIL lanes_one got=%h exp=1122cc44", out0); end
        drv_desel();
        write_word(10'h020, 32'hFFFFFFFF, 4'b1111);
        drv_load(10'h020, 1'b0, 4'hF);
        total++; if (out0 !== 32'h1122CC44) begin bad++; $display("FAIL lanes_none got=%h exp=1122cc44", out0); end
        drv_desel();
    endtask

    task automatic test_bypass();
        write_word(10'h030, 32'h12345678, 4'b0000);
        drv_load(10'h030, 1'b1, 4'b1100);
        SDATAIN = 32'h0000FFFF;
        drv_load(10'h030, 1'b0, 4'hF);
        total++; if (out0 !== 32'h1234FFFF || oe0 !== 1'b1) begin bad++; $display("FAIL bypass got=%b/%h exp=1/1234ffff", oe0, out0); end
        drv_desel();
        drv_load(10'h030, 1'b0, 4'hF);
        total++; if (out0 !== 32'h1234FFFF) begin bad++; $display("FAIL bypass_array got=%h exp=1234ffff", out0); end
        drv_desel();
    endtask

    task automatic test_burst();
        logic [31:0] d [4];
        logic [31:0] lin [4];
        logic [31:0] il [4];
        d = '{32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
        // back-to-back writes to 0x40..0x43, one per cycle
        drv_load(10'h040, 1'b1, 4'h0);
        for (int i = 1; i < 4; i++) begin
            SDATAIN = d[i-1];
            drv_load(10'h040 + 10'(i), 1'b1, 4'h0);
        end
        SDATAIN = d[3];
        drv_desel();
        // base 0x42: both orders give 2,3,0,1
        drv_load(10'h042, 1'b0, 4'hF);
        lin = '{d[2], d[3], d[0], d[1]};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drv_adv(4'hF);
            total++; if (out0 !== lin[i] || out1 !== lin[i] || oe0 !== 1'b1) begin bad++; $display("FAIL burst42[%0d] got=%h/%h exp=%h", i, out0, out1, lin[i]); end
        end
        // base 0x41: linear 1,2,3,0 vs interleaved 1,0,3,2
        drv_load(10'h041, 1'b0, 4'hF);
        lin = '{d[1], d[2], d[3], d[0]};
        il  = '{d[1], d[0], d[3], d[2]};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drv_adv(4'hF);
            total++; if (out0 !== lin[i]) begin bad++; $display("FAIL burst41_lin[%0d] got=%h exp=%h", i, out0, lin[i]); end
            total++; if (out1 !== il[i]) begin bad++; $display("FAIL burst41_il[%0d] got=%h exp=%h", i, out1, il[i]); end
        end
        drv_desel();
        // write burst from 0x46: both orders hit 0x46,0x47,0x44,0x45
        drv_load(10'h046, 1'b1, 4'h0);
        SDATAIN = 32'hE0E0E0E0; drv_adv(4'h0);
        SDATAIN = 32'hE1E1E1E1; drv_adv(4'h0);
        SDATAIN = 32'hE2E2E2E2; drv_adv(4'h0);
        SDATAIN = 32'hE3E3E3E3; drv_desel();
        drv_load(10'h044, 1'b0, 4'hF);
        total++; if (out0 !== 32'hE2E2E2E2 || out1 !== 32'hE2E2E2E2) begin bad++; $display("FAIL burst_wr got=%h/%h exp=e2e2e2e2", out0, out1); end
        drv_desel();
    endtask

    task automatic test_cke();
        // read data phase held by SnCKE
        drv_load(10'h040, 1'b0, 4'hF);
        SnCKE = 1'b1; SADVnLD = 1'b0; SnCE = 1'b0; SADDR = 10'h041;
        repeat (2) cyc();
        total++; if (out0 !== 32'hD0D0D0D0 || oe0 !== 1'b1) begin bad++; $display("FAIL cke_rd_hold got=%b/%h exp=1/d0d0d0d0", oe0, out0); end
        SnCKE = 1'b0;
        cyc();
        total++; if (out0 !== 32'hD1D1D1D1) begin bad++; $display("FAIL cke_rd_release got=%h exp=d1d1d1d1", out0); end
        drv_desel();
        // write data phase held: SDATAIN sampled at the first enabled edge
        write_word(10'h060, 32'hCAFE0000, 4'h0);
        drv_load(10'h060, 1'b1, 4'h0);
        SnCKE = 1'b1; SDATAIN = 32'h0BAD0BAD; SADVnLD = 1'b0; SnCE = 1'b0; SnWR = 1'b1; SnWBYTE = 4'hF;
        repeat (3) cyc();
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL cke_wr_oe got=%b exp=0", oe0); end
        SDATAIN = 32'h600DF00D;
        drv_desel();
        drv_load(10'h060, 1'b0, 4'hF);
        total++; if (out0 !== 32'h600DF00D) begin bad++; $display("FAIL cke_wr got=%h exp=600df00d", out0); end
        drv_desel();
    endtask

    task automatic test_error();
        HRESETn = 1'b0;
        cyc();
        HRESETn = 1'b1;
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL err_after_reset got=%b exp=0", err0); end
        SnCE = 1'b0;
        drv_adv(4'hF);
        total++; if (err0 !== 1'b1 || err1 !== 1'b1) begin bad++; $display("FAIL err_set got=%b%b exp=11", err0, err1); end
        total++; if (oe0 !== 1'b0 || out0 !== 32'h0) begin bad++; $display("FAIL err_noaccess got=%b/%h exp=0/00000000", oe0, out0); end
        drv_adv(4'hF);
        drv_desel();
        drv_load(10'h040, 1'b0, 4'hF);
        total++; if (err0 !== 1'b1 || out0 !== 32'hD0D0D0D0) begin bad++; $display("FAIL err_sticky got=%b/%h exp=1/d0d0d0d0", err0, out0); end
        drv_desel();
    endtask

    task automatic test_reset_mid_write();
        write_word(10'h050, 32'h55555555, 4'h0);
        drv_load(10'h050, 1'b0, 4'hF);
        drv_load(10'h050, 1'b1, 4'h0);
        SDATAIN = 32'hBADBAD00;
        HRESETn = 1'b0;
        drv_desel();
        total++; if (oe0 !== 1'b0 || out0 !== 32'h0 || err0 !== 1'b0) begin bad++; $display("FAIL rst_mid_outs got=%b/%h/%b exp=0/00000000/0", oe0, out0, err0); end
        HRESETn = 1'b1;
        drv_load(10'h050, 1'b0, 4'hF);
        total++; if (out0 !== 32'h55555555) begin bad++; $display("FAIL rst_mid_mem got=%h exp=55555555", out0); end
        drv_desel();
    endtask

    initial begin
        HRESETn = 1'b0; SADDR = '0; SDATAIN = 32'h0; SnWBYTE = 4'hF; SnOE = 1'b0;
        SnCE = 1'b1; SADVnLD = 1'b0; SnWR = 1'b1; SnCKE = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_bypass();
        test_burst();
        test_cke();
        test_error();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
